// File: rtl/lfsr_pixel_source_pkg.sv
// Shared definitions for the LFSR pixel source: widths, default seed,
// controller state encoding and the pure LFSR/pixel helper functions.
package lfsr_pixel_source_pkg;

  localparam int MAX_PIXEL_BITS = 24;
  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_LOAD0,
    S_LOAD1,
    S_LOAD2,
    S_LOAD3,
    S_ARMED,
    S_RUN,
    S_DONE
  } src_state_t;

  // Fibonacci step, taps 16/14/13/11 (bits 15,13,12,10)
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Pixel packing: hi byte, lo byte, hi^lo
  function automatic logic [MAX_PIXEL_BITS-1:0] lfsr_to_pixel(input logic [LFSR_WIDTH-1:0] l);
    return {l[15:8], l[7:0], l[15:8] ^ l[7:0]};
  endfunction

endpackage

// File: rtl/lfsr_pixel_source_lfsr16_core.sv
// 16-bit Fibonacci LFSR register with seed load and enable-step.
// A zero seed is replaced by LFSR_DEFAULT_SEED so the register never locks up.
module lfsr16_core
  import lfsr_pixel_source_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  load_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  input  logic                  step_i,
  output logic [LFSR_WIDTH-1:0] value_o
);

  logic [LFSR_WIDTH-1:0] lfsr_q;

  // Load has priority over step; the value holds otherwise
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      lfsr_q <= '0;
    end else if (load_i) begin
      lfsr_q <= (seed_i == '0) ? LFSR_DEFAULT_SEED : seed_i;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/lfsr_pixel_source.sv
// Built-in pixel generator: loads seed/stop from a byte stream, then emits one
// LFSR-derived pixel every PX_INTERVAL clocks until the stop code or MAX_STEPS.
// Optional build macro LFSR_SRC_COUNT_EN adds px_count_o (pixels in current/last run).
module lfsr_pixel_source
  import lfsr_pixel_source_pkg::*;
#(
  parameter int PX_WIDTH    = MAX_PIXEL_BITS,
  parameter int PX_INTERVAL = 4,
  parameter int MAX_STEPS   = 65535
) (
  input  logic                clk_i,
  input  logic                nreset_i,
  input  logic [7:0]          byte_i,
  input  logic                byte_valid_i,
  input  logic                start_i,
  output logic [PX_WIDTH-1:0] pixel_o,
  output logic                px_rdy_o,
  output logic                busy_o,
`ifdef LFSR_SRC_COUNT_EN
  output logic [15:0]         px_count_o,
`endif
  output logic                done_o
);

  localparam int CNT_W = $clog2(PX_INTERVAL);
  localparam logic [CNT_W-1:0] IVL_LAST = CNT_W'(PX_INTERVAL - 1);

  src_state_t            state_q, state_d;
  logic [15:0]           seed_q, seed_d;
  logic [15:0]           stop_q, stop_d;
  logic [CNT_W-1:0]      ivl_q, ivl_d;
  logic [15:0]           step_q, step_d;
  logic [PX_WIDTH-1:0]   pixel_q, pixel_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, done_q;
  logic                  lfsr_load, lfsr_step;
  logic [LFSR_WIDTH-1:0] lfsr_val;
`ifdef LFSR_SRC_COUNT_EN
  logic [15:0]           count_q, count_d;
`endif

  lfsr16_core u_lfsr (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .load_i   (lfsr_load),
    .seed_i   (seed_q),
    .step_i   (lfsr_step),
    .value_o  (lfsr_val)
  );

  // Next-state, config capture and pixel emission
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    stop_d    = stop_q;
    ivl_d     = ivl_q;
    step_d    = step_q;
    pixel_d   = pixel_q;
    rdy_d     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`ifdef LFSR_SRC_COUNT_EN
    count_d   = count_q;
`endif
    case (state_q)
      S_LOAD0: if (byte_valid_i) begin seed_d[15:8] = byte_i; state_d = S_LOAD1; end
      S_LOAD1: if (byte_valid_i) begin seed_d[7:0]  = byte_i; state_d = S_LOAD2; end
      S_LOAD2: if (byte_valid_i) begin stop_d[15:8] = byte_i; state_d = S_LOAD3; end
      S_LOAD3: if (byte_valid_i) begin stop_d[7:0]  = byte_i; state_d = S_ARMED; end
      S_ARMED, S_DONE: begin
        // A new byte restarts configuration and beats a simultaneous start
        if (byte_valid_i) begin
          seed_d[15:8] = byte_i;
          state_d      = S_LOAD1;
        end else if (start_i) begin
          state_d   = S_RUN;
          lfsr_load = 1'b1;
          ivl_d     = '0;
          step_d    = '0;
`ifdef LFSR_SRC_COUNT_EN
          count_d   = '0;
`endif
        end
      end
      S_RUN: begin
        if (ivl_q == IVL_LAST) begin
          ivl_d     = '0;
          pixel_d   = PX_WIDTH'(lfsr_to_pixel(lfsr_val));
          rdy_d     = 1'b1;
          step_d    = step_q + 16'd1;
          lfsr_step = 1'b1;
`ifdef LFSR_SRC_COUNT_EN
          count_d   = count_q + 16'd1;
`endif
          if ((lfsr_val == stop_q) || (step_d == 16'(MAX_STEPS))) begin
            state_d = S_DONE;
          end
        end else begin
          ivl_d = ivl_q + CNT_W'(1);
        end
      end
      default: state_d = S_LOAD0;
    endcase
  end

  // State, config, counters and registered outputs
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_LOAD0;
      seed_q  <= '0;
      stop_q  <= '0;
      ivl_q   <= '0;
      step_q  <= '0;
      pixel_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LFSR_SRC_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      stop_q  <= stop_d;
      ivl_q   <= ivl_d;
      step_q  <= step_d;
      pixel_q <= pixel_d;
      rdy_q   <= rdy_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
`ifdef LFSR_SRC_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  assign pixel_o  = pixel_q;
  assign px_rdy_o = rdy_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
`ifdef LFSR_SRC_COUNT_EN
  assign px_count_o = count_q;
`endif

endmodule

// File: tb/tb_lfsr_pixel_source.sv
// Self-checking bench for lfsr_pixel_source (MAX_STEPS reduced to 8).
module tb_lfsr_pixel_source;

  localparam int PXI  = 4;
  localparam int MAXS = 8;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [7:0]  byte_v = 8'h00;
  logic        bvalid = 1'b0;
  logic        start = 1'b0;
  logic [23:0] pixel;
  logic        px_rdy, busy, done;
`ifdef LFSR_SRC_COUNT_EN
  logic [15:0] px_count;
`endif

  always #5 clk = ~clk;

  lfsr_pixel_source #(.PX_WIDTH(24), .PX_INTERVAL(PXI), .MAX_STEPS(MAXS)) dut (
    .clk_i        (clk),
    .nreset_i     (nreset),
    .byte_i       (byte_v),
    .byte_valid_i (bvalid),
    .start_i      (start),
    .pixel_o      (pixel),
    .px_rdy_o     (px_rdy),
    .busy_o       (busy),
`ifdef LFSR_SRC_COUNT_EN
    .px_count_o   (px_count),
`endif
    .done_o       (done)
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    string       name;
    logic [15:0] seed;
    logic [15:0] stop;
    int          n;
    logic [23:0] p[3];
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sequence of pixels a run must produce, from the stated rules
  function automatic logic [15:0] m_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic build_model(input logic [15:0] seed, input logic [15:0] stop);
    logic [15:0] l;
    exp_q.delete();
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    while (1) begin
      exp_q.push_back({l[15:8], l[7:0], l[15:8] ^ l[7:0]});
      if (l == stop || exp_q.size() == MAXS) break;
      l = m_step(l);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bvalid = 1'b1;
    byte_v = b;
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] seed, input logic [15:0] stop);
    send_byte(seed[15:8]);
    send_byte(seed[7:0]);
    send_byte(stop[15:8]);
    send_byte(stop[7:0]);
  endtask

  // Pulse start, collect strobes until done_o, compare against exp_q
  task automatic run(input string tag, input bit noise);
    int k;
    int n;
    bit fin;
    k = 0; n = 0; fin = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_at_start"}, {31'd0, busy}, 32'd1);
    while (!fin) begin
      bvalid = noise && busy && ($urandom_range(0, 1) == 1);
      byte_v = 8'($urandom);
      @(negedge clk);
      k++;
      if (px_rdy) begin
        if (n < exp_q.size()) chk({tag, " pixel"}, {8'd0, pixel}, {8'd0, exp_q[n]});
        else chk({tag, " extra_strobe"}, n, exp_q.size());
        chk({tag, " strobe_time"}, k, PXI * (n + 1));
        n++;
      end
      if (done) fin = 1;
      else if (k > PXI * (MAXS + 2)) begin
        chk({tag, " timeout"}, 32'd0, 32'd1);
        fin = 1;
      end
    end
    bvalid = 1'b0;
    chk({tag, " strobe_count"}, n, exp_q.size());
    chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
`ifdef LFSR_SRC_COUNT_EN
    chk({tag, " px_count"}, {16'd0, px_count}, n);
`endif
    @(negedge clk);
    chk({tag, " rdy_after_done"}, {31'd0, px_rdy}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{"t1_seed_eq_stop", 16'h0001, 16'h0001, 1, '{24'h000101, 24'h0, 24'h0}};
    tbl[1] = '{"t2_three_px",     16'hACE1, 16'hB387, 3, '{24'hACE14D, 24'h59C39A, 24'hB38734}};
    tbl[2] = '{"t3_zero_seed",    16'h0000, 16'hACE1, 1, '{24'hACE14D, 24'h0, 24'h0}};
    tbl[3] = '{"t6_max_steps",    16'hACE1, 16'h0000, 8, '{24'hACE14D, 24'h59C39A, 24'hB38734}};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset pixel", {8'd0, pixel}, 32'd0);
    chk("reset rdy", {31'd0, px_rdy}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Table-driven runs; expectations come from the table, tail from the model
    for (int i = 0; i < 4; i++) begin
      load_cfg(tbl[i].seed, tbl[i].stop);
      build_model(tbl[i].seed, tbl[i].stop);
      while (exp_q.size() > tbl[i].n) void'(exp_q.pop_back());
      for (int j = 0; j < 3 && j < tbl[i].n; j++) exp_q[j] = tbl[i].p[j];
      run(tbl[i].name, 1'b0);
      chk({tbl[i].name, " done"}, {31'd0, done}, 32'd0 + (px_rdy ? 0 : 1));
    end

    // Bytes during the run are ignored; start in done replays the same run
    load_cfg(16'hACE1, 16'hB387);
    build_model(16'hACE1, 16'hB387);
    run("t4_noise", 1'b1);
    run("t4_replay", 1'b0);

    // Start and byte together in done: reload wins
    start = 1'b1; bvalid = 1'b1; byte_v = 8'h00;
    @(negedge clk);
    start = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    chk("reload_wins busy", {31'd0, busy}, 32'd0);
    chk("reload_wins done", {31'd0, done}, 32'd0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    build_model(16'h0001, 16'h0001);
    run("reload_wins run", 1'b0);

    // Reset between the 2nd and 3rd strobe
    begin
      int seen;
      int k;
      bit hit;
      load_cfg(16'hACE1, 16'hB387);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0; k = 0;
      while (seen < 2 && k < 40) begin
        @(negedge clk);
        k++;
        if (px_rdy) seen++;
      end
      chk("t5 two_strobes", seen, 2);
      @(negedge clk);
      nreset = 1'b0;
      #1;
      chk("t5 pixel_cleared", {8'd0, pixel}, 32'd0);
      chk("t5 rdy_cleared", {31'd0, px_rdy}, 32'd0);
      chk("t5 busy_cleared", {31'd0, busy}, 32'd0);
      chk("t5 done_cleared", {31'd0, done}, 32'd0);
      @(negedge clk);
      nreset = 1'b1;
      start = 1'b1;
      hit = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (px_rdy || busy || done) hit = 1;
      end
      start = 1'b0;
      chk("t5 no_run_without_reload", {31'd0, hit}, 32'd0);
    end

    // Randomized seeds/stops against the model
    for (int r = 0; r < 8; r++) begin
      logic [15:0] s, t;
      int steps;
      s = 16'($urandom);
      steps = $urandom_range(0, 10);
      t = (s == 16'h0000) ? 16'hACE1 : s;
      for (int q = 0; q < steps; q++) t = m_step(t);
      if (r % 4 == 3) t = 16'($urandom);
      load_cfg(s, t);
      build_model(s, t);
      run($sformatf("rand%0d", r), r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
